// File: rtl/sdp_rdma_pack_arb.sv
// Packet-atomic round-robin arbiter sharing one SDP RDMA pack datapath between NREQ
// read-return streams, followed by a single full-throughput output register stage.
module sdp_rdma_pack_arb #(
  parameter int unsigned IW   = 512,
  parameter int unsigned CW   = 1,
  parameter int unsigned NREQ = 2,
  parameter int unsigned SW   = 1
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic [NREQ-1:0]           cfg_req_mask,
  input  logic [NREQ-1:0]           req_pvld,
  output logic [NREQ-1:0]           req_prdy,
  input  logic [NREQ*(IW+CW)-1:0]   req_data,
  output logic                      out_pvld,
  input  logic                      out_prdy,
  output logic [IW+CW-1:0]          out_data,
  output logic [SW-1:0]             out_src,
  output logic                      arb_busy
);

  localparam int unsigned W = IW + CW;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] lock_q, lock_d;
  logic          out_pvld_q, out_pvld_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;

  logic          pipe_rdy;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] cand_idx;
  logic [W-1:0]  gnt_beat;
  logic          acc;
  logic          eop;

  assign pipe_rdy = !out_pvld_q || out_prdy;

  // Idle: first unmasked valid requester after rr_ptr. Busy: only the locked one.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = lock_q;
    cand_idx = '0;
    if (state_q == StBusy) begin
      gnt_vld = req_pvld[lock_q];
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand_idx = SW'((32'(rr_ptr_q) + k) % NREQ);
        if (!gnt_vld && req_pvld[cand_idx] && !cfg_req_mask[cand_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
  end

  assign gnt_beat = req_data[32'(gnt_idx) * W +: W];
  assign acc      = gnt_vld && pipe_rdy;
  assign eop      = gnt_beat[W-1];

  always_comb begin
    req_prdy = '0;
    if (acc) begin
      req_prdy[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    out_pvld_d = out_pvld_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    if (acc) begin
      out_pvld_d = 1'b1;
      out_data_d = gnt_beat;
      out_src_d  = gnt_idx;
      if (eop) begin
        state_d  = StIdle;
        rr_ptr_d = gnt_idx;
      end else begin
        state_d = StBusy;
        lock_d  = gnt_idx;
      end
    end else if (out_prdy) begin
      out_pvld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= SW'(NREQ - 1);
      lock_q     <= '0;
      out_pvld_q <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      out_pvld_q <= out_pvld_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_pvld = out_pvld_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;
  assign arb_busy = (state_q == StBusy);

endmodule

// File: tb/tb_sdp_rdma_pack_arb.sv
// Randomized bench for sdp_rdma_pack_arb: packet-level arbitration model plus an
// output scoreboard fed at grant time and drained by an independent monitor.
module tb_sdp_rdma_pack_arb;

  localparam int IW   = 16;
  localparam int CW   = 1;
  localparam int NREQ = 2;
  localparam int SW   = 1;
  localparam int W    = IW + CW;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      mask;
  logic [NREQ-1:0]      pvld;
  logic [NREQ-1:0]      prdy;
  logic [NREQ*W-1:0]    rdata;
  logic                 opvld;
  logic                 oprdy;
  logic [W-1:0]         odata;
  logic [SW-1:0]        osrc;
  logic                 busy;

  always #5 clk = ~clk;

  sdp_rdma_pack_arb #(
    .IW   (IW),
    .CW   (CW),
    .NREQ (NREQ),
    .SW   (SW)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .cfg_req_mask    (mask),
    .req_pvld        (pvld),
    .req_prdy        (prdy),
    .req_data        (rdata),
    .out_pvld        (opvld),
    .out_prdy        (oprdy),
    .out_data        (odata),
    .out_src         (osrc),
    .arb_busy        (busy)
  );

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  beat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] src_q[NREQ][$];

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus knobs
  int              vprob = 100;
  int              rprob = 100;
  bit              single = 1'b0;
  bit              rand_mask = 1'b0;
  logic [NREQ-1:0] en = '1;

  // reference model: packet-level round robin
  bit m_busy;
  int m_lock;
  int m_rr;
  bit m_opvld;

  bit            fair_mode = 1'b0;
  bit            have_last = 1'b0;
  logic [SW-1:0] last_src;
  int            gnt1_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void gen_pkt(input int i);
    int           len;
    logic [W-1:0] bt;
    len = single ? 1 : int'($urandom_range(1, 4));
    for (int b = 0; b < len; b++) begin
      bt         = '0;
      bt[IW-1:0] = IW'($urandom);
      bt[W-1]    = (b == len - 1);
      src_q[i].push_back(bt);
    end
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_lock  = 0;
    m_rr    = NREQ - 1;
    m_opvld = 1'b0;
  endtask

  task automatic model_step();
    bit              rdy;
    bit              have;
    int              g;
    int              c;
    logic [NREQ-1:0] ep;
    logic [W-1:0]    bt;
    exp_t            e;
    rdy  = !m_opvld || oprdy;
    have = 1'b0;
    g    = 0;
    if (m_busy) begin
      g    = m_lock;
      have = pvld[g];
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_rr + k) % NREQ;
        if (!have && pvld[c] && !mask[c]) begin
          have = 1'b1;
          g    = c;
        end
      end
    end
    ep = '0;
    if (have && rdy) ep[g] = 1'b1;
    chk("req_prdy", prdy, ep);
    chk("out_pvld", opvld, m_opvld);
    chk("arb_busy", busy, m_busy);
    if (have && rdy) begin
      bt     = src_q[g][0];
      e.src  = SW'(g);
      e.beat = bt;
      exp_q.push_back(e);
      if (bt[W-1]) begin
        m_busy = 1'b0;
        m_rr   = g;
      end else begin
        m_busy = 1'b1;
        m_lock = g;
      end
      m_opvld = 1'b1;
    end else if (oprdy) begin
      m_opvld = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (pvld[i] && prdy[i]) void'(src_q[i].pop_front());
    end
  endtask

  // Drive on the falling edge, evaluate 2ns later, commit on the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (rand_mask) mask = NREQ'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() == 0) gen_pkt(i);
      pvld[i]            = en[i] && (int'($urandom_range(0, 99)) < vprob);
      rdata[i*W +: W]    = src_q[i][0];
    end
    oprdy = (int'($urandom_range(0, 99)) < rprob);
    #2;
    model_step();
    if (prdy[1]) gnt1_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn  = 1'b0;
    pvld  = '0;
    oprdy = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_out_pvld", opvld, 0);
    chk("rst_out_data", odata, 0);
    chk("rst_out_src", osrc, 0);
    chk("rst_arb_busy", busy, 0);
    rstn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    model_reset();
  endtask

  // output monitor
  initial begin
    exp_t          e;
    logic [SW-1:0] alt;
    forever begin
      @(negedge clk);
      #3;
      if (rstn && opvld && oprdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got src=%0d data=%0h expected no beat", osrc, odata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", odata, e.beat);
          chk("out_src", osrc, e.src);
          if (fair_mode && have_last) begin
            alt = ~last_src;
            chk("rr_alternate", osrc, alt);
          end
          last_src  = osrc;
          have_last = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  hold_d;
    logic [SW-1:0] hold_s;
    logic [W-1:0]  bt;
    bit [3:0]      p1_busy;
    rstn  = 1'b0;
    mask  = '0;
    pvld  = '0;
    oprdy = 1'b0;
    rdata = '0;
    model_reset();
    do_reset();

    // single requester, one 3-beat packet
    en = 2'b01;
    for (int b = 0; b < 3; b++) begin
      bt         = '0;
      bt[IW-1:0] = IW'($urandom);
      bt[W-1]    = (b == 2);
      src_q[0].push_back(bt);
    end
    p1_busy = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("p1_busy", busy, p1_busy[k]);
    end
    en = '1;

    // fairness with single-beat packets
    do_reset();
    single = 1'b1;
    repeat (3) cycle();
    have_last = 1'b0;
    fair_mode = 1'b1;
    repeat (30) cycle();
    fair_mode = 1'b0;
    single    = 1'b0;

    // random multi-beat traffic, then with backpressure
    vprob = 70;
    repeat (300) cycle();
    rprob = 60;
    repeat (300) cycle();

    // directed backpressure hold mid-packet
    vprob = 100;
    rprob = 100;
    for (int k = 0; k < 200 && !(m_busy && m_opvld); k++) cycle();
    chk("bp_reach_busy", busy, 1);
    rprob = 0;
    cycle();
    hold_d = odata;
    hold_s = osrc;
    repeat (5) begin
      cycle();
      chk("bp_data_hold", odata, hold_d);
      chk("bp_src_hold", osrc, hold_s);
      chk("bp_no_prdy", prdy, 0);
    end
    rprob = 100;
    repeat (20) cycle();

    // mask requester 0
    do_reset();
    mask     = 2'b01;
    gnt1_cnt = 0;
    repeat (40) begin
      cycle();
      chk("mask_req0_blocked", prdy[0], 0);
    end
    chk("mask_req1_granted", 64'(gnt1_cnt > 0), 1);

    // masking the locked requester mid-packet must not break the lock
    mask = '0;
    en   = 2'b10;
    for (int k = 0; k < 200 && !(busy && m_lock == 1); k++) cycle();
    chk("lock_req1_busy", busy, 1);
    en   = '1;
    mask = 2'b10;
    for (int k = 0; k < 50 && busy; k++) cycle();
    chk("masked_lock_done", busy, 0);
    mask = '0;

    // random mask and backpressure
    rand_mask = 1'b1;
    vprob     = 80;
    rprob     = 70;
    repeat (200) cycle();
    rand_mask = 1'b0;
    mask      = '0;

    // reset in the middle of a packet
    vprob = 100;
    rprob = 100;
    for (int k = 0; k < 200 && !busy; k++) cycle();
    chk("mid_reset_busy", busy, 1);
    do_reset();
    cycle();
    chk("first_grant_after_reset", prdy, 2'b01);
    repeat (20) cycle();

    // drain
    vprob = 0;
    repeat (5) cycle();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdp_rdma_pack_arb.md
Name: sdp_rdma_pack_arb

Overview:
Packet-atomic round-robin arbiter that shares one SDP RDMA pack/unpack datapath between NREQ read-return streams, for example MRDMA and BRDMA returns feeding a single pack unit. Each stream delivers beats of {ctrl, data}; the ctrl MSB marks the last beat of a packet. Once a requester wins, it is locked until its last beat is accepted, so packets are never interleaved. The output is a single full-throughput register stage that drives the pack unit's inp_pvld/inp_prdy/inp_data.

Parameters:
IW, 512, data width per beat
CW, 1, control width per beat; bit IW+CW-1 (ctrl MSB) is the end-of-packet (eop) flag
NREQ, 2, number of requesters (2..4)
SW, 1, width of the source index; must be at least clog2(NREQ)

Ports:
nvdla_core_clk  input  1  core clock; the only clock in the block
nvdla_core_rstn  input  1  reset, synchronous, active-low
cfg_req_mask  input  NREQ  bit i=1 blocks new grants to requester i
req_pvld  input  NREQ  per-requester beat valid
req_prdy  output  NREQ  per-requester beat ready
req_data  input  NREQ*(IW+CW)  flattened beats; requester i occupies bits [(i+1)*(IW+CW)-1 : i*(IW+CW)]
out_pvld  output  1  registered beat valid to the pack unit
out_prdy  input  1  pack unit ready
out_data  output  IW+CW  registered beat {ctrl, data}
out_src  output  SW  index of the requester that sourced out_data
arb_busy  output  1  1 while a multi-beat packet is locked

Behaviour:
- Reset (sync, nvdla_core_rstn=0 sampled at a clock edge):
  - out_pvld=0, out_data=0, out_src=0, arb_busy=0.
  - state=IDLE, rr_ptr=NREQ-1, so requester 0 has highest priority first.
- Pipe stage:
  - pipe_rdy = !out_pvld | out_prdy.
  - A beat accepted from requester g loads out_data/out_src and sets out_pvld=1 on the next edge. Latency is 1 cycle.
  - If out_acc occurs with no new beat, out_pvld goes to 0.
  - If out_pvld=1 and out_prdy=0, the register holds and all req_prdy are 0.
- Arbitration in IDLE (combinational, same cycle):
  - Candidates are requesters with req_pvld[i]=1 and cfg_req_mask[i]=0.
  - Winner g is the first candidate searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_prdy[g]=pipe_rdy; all other req_prdy=0.
  - With no candidate, all req_prdy=0.
- Accepted beat in IDLE:
  - eop=1: stay IDLE, rr_ptr<=g (single-beat packet).
  - eop=0: go to BUSY with lock=g, arb_busy<=1.
- BUSY:
  - req_prdy[lock]=pipe_rdy; all other req_prdy=0, regardless of their valids or the mask.
  - Accepted beat with eop=1: go to IDLE, rr_ptr<=lock, arb_busy<=0.
  - A bubble (req_pvld[lock]=0) holds BUSY indefinitely.
- Mask handling:
  - Mask changes affect only new grants.
  - Masking the locked requester mid-packet does not break the lock.
- Back-to-back throughput:
  - A new packet may be granted in the same cycle the previous eop sits in the out register, provided out_prdy=1.
  - One beat per cycle is sustained; there are no idle cycles between packets of different requesters.
- req_prdy is never asserted for a requester with req_pvld=0.
- Reset asserted mid-packet:
  - State returns to IDLE, out_pvld=0, and any partial packet is dropped.
  - Upstream is responsible for flushing.

Test Plan:
- Reset then a single requester: NREQ=2, req0 sends a 3-beat packet (eop on beat 3) with out_prdy=1 -> out_pvld high cycles 1..3 after the first accept, out_src=0, arb_busy=1 for beats 1-2, back to IDLE after beat 3.
- Round-robin fairness: req0 and req1 both continuously valid with single-beat (eop) packets -> out_src sequence 0,1,0,1..., one beat per cycle.
- Packet atomicity: req1 is granted a 4-beat packet, and req0 goes valid at beat 2 -> req_prdy[0]=0 until req1's eop is accepted; req0 is granted the next cycle; no interleave in out_data.
- Backpressure: out_prdy=0 for 5 cycles mid-packet -> out_data/out_src stable, all req_prdy=0; resume with no lost or duplicated beat (compare against a scoreboard).
- Mask: cfg_req_mask=2'b01 with both valid -> only req1 is granted; setting the mask bit of the locked requester mid-packet -> the packet still completes.
- Reset mid-packet: assert rstn=0 for 1 cycle during BUSY -> out_pvld=0, arb_busy=0, rr_ptr=NREQ-1; the next grant goes to req0 when both are valid.
